muldiv_ctrl: RTL

- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the P7 pipeline.
- Sits beside the ALU in the EX stage. Accepts an operation from ID/EX, runs a fixed-latency countdown, and commits the result to HI/LO.
- Raises a stall request so the hazard unit holds any HI/LO-dependent instruction in ID.
- Honours the interrupt-cancel line (same role as IntBeq in the stage registers) so a victim instruction never starts an operation.

---
 rtl/muldiv_ctrl_pkg.sv | 21 ++
 rtl/muldiv_ctrl_md_arith.sv | 69 ++++++
 rtl/muldiv_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: operation codes
// and the two-state sequencer FSM.
package muldiv_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam int MD_CNT_W = 4;

endpackage

// File: rtl/muldiv_ctrl_md_arith.sv
// Combinational multiply/divide datapath producing the 64-bit HI:LO result,
// including the MIPS-style divide-by-zero and signed-overflow outcomes.
module md_arith
   import muldiv_ctrl_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic        w_is_signed;
   logic        w_neg_a;
   logic        w_neg_b;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [31:0] w_div_b;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic        w_div_zero;
   logic        w_ovf;

   // Low 64 bits of the sign-extended product equal the signed 32x32 product.
   assign w_prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
   assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

   // Signed division works on magnitudes; quotient truncates toward zero and
   // the remainder follows the dividend's sign.
   assign w_is_signed = (op == MD_DIV);
   assign w_neg_a     = w_is_signed & src_a[31];
   assign w_neg_b     = w_is_signed & src_b[31];
   assign w_mag_a     = w_neg_a ? (32'd0 - src_a) : src_a;
   assign w_mag_b     = w_neg_b ? (32'd0 - src_b) : src_b;
   assign w_div_zero  = (src_b == 32'd0);
   assign w_div_b     = w_div_zero ? 32'd1 : w_mag_b;
   assign w_q_mag     = w_mag_a / w_div_b;
   assign w_r_mag     = w_mag_a % w_div_b;
   assign w_quot      = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem       = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;
   assign w_ovf       = w_is_signed & (src_a == 32'h8000_0000) & (src_b == 32'hFFFF_FFFF);

   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (op)
         MD_MULT:  {res_hi, res_lo} = w_prod_s;
         MD_MULTU: {res_hi, res_lo} = w_prod_u;
         MD_DIV, MD_DIVU: begin
            if (w_div_zero) begin
               res_lo = 32'hFFFF_FFFF;
               res_hi = src_a;
            end else if (w_ovf) begin
               res_lo = 32'h8000_0000;
               res_hi = 32'd0;
            end else begin
               res_lo = w_quot;
               res_hi = w_rem;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the EX stage: accepts mult/div/mthi/mtlo, runs a fixed
// countdown, commits the pending result, and requests ID stalls meanwhile.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        int_cancel,
   input  logic        md_use_d,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES - 1);
   localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES - 1);

   md_state_e           r_state;
   md_state_e           w_state_next;
   logic [MD_CNT_W-1:0] r_cnt;
   logic [MD_CNT_W-1:0] w_cnt_next;
   logic [31:0]         r_pend_hi, w_pend_hi_next;
   logic [31:0]         r_pend_lo, w_pend_lo_next;
   logic [31:0]         r_hi, w_hi_next;
   logic [31:0]         r_lo, w_lo_next;
   logic [31:0]         w_res_hi;
   logic [31:0]         w_res_lo;
   logic                w_eff_start;

   md_arith u_arith (
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .res_hi (w_res_hi),
      .res_lo (w_res_lo)
   );

   // A flushed EX instruction must never start, even for one cycle.
   assign w_eff_start = start & ~int_cancel & (r_state == ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_pend_hi <= w_pend_hi_next;
         r_pend_lo <= w_pend_lo_next;
         r_hi      <= w_hi_next;
         r_lo      <= w_lo_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_pend_hi_next = r_pend_hi;
      w_pend_lo_next = r_pend_lo;
      w_hi_next      = r_hi;
      w_lo_next      = r_lo;
      case (r_state)
         ST_IDLE: begin
            if (w_eff_start) begin
               case (op)
                  MD_MTHI: w_hi_next = src_a;
                  MD_MTLO: w_lo_next = src_a;
                  MD_MULT, MD_MULTU: begin
                     w_pend_hi_next = w_res_hi;
                     w_pend_lo_next = w_res_lo;
                     w_cnt_next     = MULT_LOAD;
                     w_state_next   = ST_RUN;
                  end
                  MD_DIV, MD_DIVU: begin
                     w_pend_hi_next = w_res_hi;
                     w_pend_lo_next = w_res_lo;
                     w_cnt_next     = DIV_LOAD;
                     w_state_next   = ST_RUN;
                  end
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            // Commit on the edge where the countdown has reached zero.
            if (r_cnt == '0) begin
               w_hi_next    = r_pend_hi;
               w_lo_next    = r_pend_lo;
               w_state_next = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign busy      = (r_state == ST_RUN);
   assign stall_req = md_use_d & (busy | w_eff_start);
   assign hi        = r_hi;
   assign lo        = r_lo;

endmodule
